// File: rtl/slicel_cfg_pkg.sv
// Shared constants and FSM state type for the SLICEL configuration loader.
// Values here describe the default slice geometry (4 LUTs of 4 inputs).
package slicel_cfg_pkg;

  localparam int S_XX_BASE = 4;
  localparam int NUM_LUTS  = 4;
  localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1;
  localparam int MUX_LVLS  = $clog2(NUM_LUTS);
  localparam int CFG_BITS  = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS;

  // Field offsets inside the shadow register (bit k of the stream lands in bit k)
  localparam int LUT_LSB  = 0;
  localparam int MUX_LSB  = CFG_SIZE * NUM_LUTS;
  localparam int CC_BIT   = MUX_LSB + MUX_LVLS;
  localparam int REGS_LSB = CC_BIT + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/slicel_cfg_loader_shift.sv
// Serial-in shadow register with accepted-bit counter and running parity.
// The first accepted bit ends up in shadow[0] once CFG_BITS bits have been
// shifted in; bits beyond CFG_BITS (the parity bit) only feed the parity.
module slicel_cfg_shift #(
  parameter int CFG_BITS   = 143,
  parameter int TOTAL_BITS = 143,
  parameter int CNT_W      = 8
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                clr,
  input  logic                accept,
  input  logic                bit_in,
  output logic [CFG_BITS-1:0] shadow,
  output logic [CNT_W-1:0]    count,
  output logic                parity
);

  // Shift in accepted bits; counter saturates at the stream length
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      count  <= '0;
      parity <= 1'b0;
    end else if (accept && (count != CNT_W'(TOTAL_BITS))) begin
      if (count < CNT_W'(CFG_BITS)) begin
        shadow <= {bit_in, shadow[CFG_BITS-1:1]};
      end
      count  <= count + 1'b1;
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/slicel_cfg_loader.sv
// SLICEL configuration loader: receives a serial bitstream LSB first, holds it
// in a shadow register and commits it to the slice config outputs in one cycle.
// Optional feature: define CFG_PARITY_EN to append and check an even-parity bit.
module slicel_cfg_loader #(
  parameter int S_XX_BASE = slicel_cfg_pkg::S_XX_BASE,
  parameter int NUM_LUTS  = slicel_cfg_pkg::NUM_LUTS,
  parameter int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS)
) (
  input  logic                         cclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cfg_bit,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic                         config_use_cc,
  output logic [2*NUM_LUTS-1:0]        regs_config_in,
  output logic                         cen,
  output logic                         cfg_done,
  output logic                         cfg_err
);

  localparam int CFG_BITS = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS;
`ifdef CFG_PARITY_EN
  localparam int TOTAL_BITS = CFG_BITS + 1;
`else
  localparam int TOTAL_BITS = CFG_BITS;
`endif
  localparam int CNT_W   = $clog2(CFG_BITS + 1);
  localparam int L_MUX   = CFG_SIZE * NUM_LUTS;
  localparam int L_CC    = L_MUX + MUX_LVLS;
  localparam int L_REGS  = L_CC + 1;

  import slicel_cfg_pkg::*;

  cfg_state_e          state;
  logic [CFG_BITS-1:0] shadow;
  logic [CNT_W-1:0]    count;
  logic                parity;
  logic                accept;
  logic                last_bit;
  logic                clr;
  logic                check_ok;

  // cfg_ready is only ever high in SHIFT, so it alone gates acceptance
  assign accept   = cfg_valid & cfg_ready;
  assign last_bit = accept && (count == CNT_W'(TOTAL_BITS - 1));
  assign clr      = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef CFG_PARITY_EN
  logic err_q;
  assign check_ok = ~parity;
  assign cfg_err  = err_q;
`else
  logic unused_parity;
  assign unused_parity = parity;
  assign check_ok      = 1'b1;
  assign cfg_err       = 1'b0;
`endif

  slicel_cfg_shift #(
    .CFG_BITS  (CFG_BITS),
    .TOTAL_BITS(TOTAL_BITS),
    .CNT_W     (CNT_W)
  ) u_shift (
    .cclk  (cclk),
    .rst   (rst),
    .clr   (clr),
    .accept(accept),
    .bit_in(cfg_bit),
    .shadow(shadow),
    .count (count),
    .parity(parity)
  );

  // Load sequencing FSM with registered handshake/status and committed config
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      cfg_ready            <= 1'b0;
      cen                  <= 1'b1;
      cfg_done             <= 1'b0;
      luts_config_in       <= '0;
      inter_lut_mux_config <= '0;
      config_use_cc        <= 1'b0;
      regs_config_in       <= '0;
`ifdef CFG_PARITY_EN
      err_q                <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SHIFT;
            cfg_ready <= 1'b1;
`ifdef CFG_PARITY_EN
            err_q     <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state     <= ST_CHECK;
            cfg_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (check_ok) begin
            state <= ST_COMMIT;
          end else begin
            state <= ST_IDLE;
`ifdef CFG_PARITY_EN
            err_q <= 1'b1;
`endif
          end
        end
        ST_COMMIT: begin
          luts_config_in       <= shadow[L_MUX-1:0];
          inter_lut_mux_config <= shadow[L_MUX +: MUX_LVLS];
          config_use_cc        <= shadow[L_CC];
          regs_config_in       <= shadow[L_REGS +: 2*NUM_LUTS];
          state                <= ST_DONE;
          cen                  <= 1'b0;
          cfg_done             <= 1'b1;
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_SHIFT;
            cfg_ready <= 1'b1;
            cen       <= 1'b1;
            cfg_done  <= 1'b0;
`ifdef CFG_PARITY_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b0;
          cen       <= 1'b1;
          cfg_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Randomized self-checking bench for slicel_cfg_loader with a bit-stream level
// reference model (received bits, commit countdown, committed image).
module tb_slicel_cfg_loader;
  import slicel_cfg_pkg::*;

  localparam int NB = CFG_BITS;
  localparam int NL = CFG_SIZE * NUM_LUTS;
`ifdef CFG_PARITY_EN
  localparam int TOT = NB + 1;
`else
  localparam int TOT = NB;
`endif

  logic cclk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [NL-1:0] luts_config_in;
  logic [MUX_LVLS-1:0] inter_lut_mux_config;
  logic config_use_cc;
  logic [2*NUM_LUTS-1:0] regs_config_in;
  logic cen, cfg_done, cfg_err;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  bit cmp_en = 1'b0;

  // reference model state
  bit m_load = 1'b0;
  int m_cnt = 0;
  int m_cd = 0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  logic [TOT-1:0] m_rx = '0;
  logic [NB-1:0] m_cfg = '0;

  slicel_cfg_loader dut (
    .cclk(cclk), .rst(rst), .start(start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .luts_config_in(luts_config_in),
    .inter_lut_mux_config(inter_lut_mux_config), .config_use_cc(config_use_cc),
    .regs_config_in(regs_config_in), .cen(cen), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] build(input logic [NL-1:0] l, input logic [1:0] m,
                                          input logic c, input logic [7:0] r);
    return {r, c, m, l};
  endfunction

  function automatic logic [TOT-1:0] mk_stream(input logic [NB-1:0] v);
    logic [TOT-1:0] s;
    s = '0;
    s[NB-1:0] = v;
`ifdef CFG_PARITY_EN
    s[NB] = ^v;
`endif
    return s;
  endfunction

  function automatic logic [NB-1:0] rand_vec();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  // Reference model: a load is a run of TOT accepted bits, then two cycles
  // (check, commit) before the received image becomes the configuration.
  initial begin
    forever begin
      @(posedge cclk or posedge rst);
      if (rst) begin
        m_load = 0; m_cnt = 0; m_cd = 0; m_done = 0; m_err = 0; m_rx = '0; m_cfg = '0;
      end else if (m_cd == 2) begin
`ifdef CFG_PARITY_EN
        if ((^m_rx) == 1'b0) m_cd = 1;
        else begin m_cd = 0; m_err = 1; end
`else
        m_cd = 1;
`endif
      end else if (m_cd == 1) begin
        m_cd = 0;
        m_cfg = m_rx[NB-1:0];
        m_done = 1;
      end else if (m_load) begin
        if (cfg_valid) begin
          m_rx[m_cnt] = cfg_bit;
          m_cnt++;
          if (m_cnt == TOT) begin m_load = 0; m_cd = 2; end
        end
      end else if (start) begin
        m_load = 1; m_cnt = 0; m_err = 0; m_done = 0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  initial begin
    forever begin
      @(negedge cclk);
      if (cmp_en) begin
        if (cfg_ready) rdy_cnt++;
        check("cfg_ready", cfg_ready, m_load);
        check("cen", cen, !m_done);
        check("cfg_done", cfg_done, m_done);
        check("cfg_err", cfg_err, m_err);
        check("luts", luts_config_in, m_cfg[NL-1:0]);
        check("mux", inter_lut_mux_config, m_cfg[NL+1:NL]);
        check("use_cc", config_use_cc, m_cfg[NL+2]);
        check("regs", regs_config_in, m_cfg[NB-1:NL+3]);
      end
    end
  end

  task automatic do_start();
    @(negedge cclk);
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
  endtask

  // Drive a stream; mode 0 = valid always, 1 = toggle starting low, 2 = random.
  // hook_kind 1 pulses start once at hook_at; 2 pulses rst after bit hook_at.
  task automatic send_stream(input logic [TOT-1:0] v, input int mode, input int hook_at,
                             input int hook_kind);
    int sent = 0;
    int budget = 0;
    bit ph = 1'b0;
    bit hooked = 1'b0;
    bit acc;
    while (sent < TOT) begin
      if (budget++ > 4000) begin
        checks++; errors++;
        $display("FAIL stream_timeout sent=%0d required=%0d", sent, TOT);
        break;
      end
      case (mode)
        0: cfg_valid = 1'b1;
        1: begin cfg_valid = ph; ph = ~ph; end
        default: cfg_valid = ($urandom_range(0, 3) != 0);
      endcase
      cfg_bit = v[sent];
      if (hook_kind == 1 && sent == hook_at && !hooked) begin start = 1'b1; hooked = 1'b1; end
      if (hook_kind == 2 && sent == hook_at + 1) begin
        cfg_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge cclk);
        check("rst_cen", cen, 1);
        check("rst_done", cfg_done, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_luts", luts_config_in, 0);
        check("rst_regs", regs_config_in, 0);
        #2 rst = 1'b0;
        @(negedge cclk);
        return;
      end
      acc = cfg_valid && cfg_ready;
      @(posedge cclk);
      if (acc) sent++;
      @(negedge cclk);
      start = 1'b0;
    end
    cfg_valid = 1'b0;
  endtask

  // Called at the falling edge right after the last bit was accepted
  task automatic finish_load(input bit ok, input string tag);
    check({tag, "_n0_done"}, cfg_done, 0);
    check({tag, "_n0_ready"}, cfg_ready, 0);
    @(negedge cclk);
    if (ok) begin
      check({tag, "_n1_done"}, cfg_done, 0);
      check({tag, "_n1_cen"}, cen, 1);
      @(negedge cclk);
      check({tag, "_n2_done"}, cfg_done, 1);
      check({tag, "_n2_cen"}, cen, 0);
    end else begin
      check({tag, "_err"}, cfg_err, 1);
      check({tag, "_err_done"}, cfg_done, 0);
      check({tag, "_err_cen"}, cen, 1);
    end
  endtask

  task automatic idle_noise();
    repeat ($urandom_range(1, 4)) begin
      @(negedge cclk);
      cfg_valid = 1'($urandom);
      cfg_bit = 1'($urandom);
    end
    @(negedge cclk);
    cfg_valid = 1'b0;
  endtask

  logic [NB-1:0] vec_a, vec_b, vec_r;
  logic [TOT-1:0] s;

  initial begin
    vec_a = build({NL{1'b1}}, 2'b10, 1'b1, 8'hA5);
    vec_b = build({NL{1'b1}}, 2'b10, 1'b1, 8'h00);

    #1 rst = 1'b1;
    repeat (2) @(negedge cclk);
    cmp_en = 1'b1;
    check("reset_cen", cen, 1);
    check("reset_done", cfg_done, 0);
    check("reset_ready", cfg_ready, 0);
    check("reset_err", cfg_err, 0);
    check("reset_luts", luts_config_in, 0);
    #2 rst = 1'b0;
    idle_noise();

    // Load A, valid every cycle
    do_start();
    send_stream(mk_stream(vec_a), 0, 0, 0);
    finish_load(1'b1, "loadA");
    check("A_regs", regs_config_in, 8'hA5);
    check("A_cc", config_use_cc, 1);
    check("A_mux", inter_lut_mux_config, 2'b10);
    check("A_luts", luts_config_in, {NL{1'b1}});
    check("model_A_regs", m_cfg[NB-1:NL+3], 8'hA5);
    idle_noise();

    // Same stream with cfg_valid toggling
    rdy_cnt = 0;
    do_start();
    send_stream(mk_stream(vec_a), 1, 0, 0);
    finish_load(1'b1, "toggle");
    check("toggle_ready_cycles", rdy_cnt, 2 * TOT);
    check("toggle_regs", regs_config_in, 8'hA5);

    // Reload with regs=00: old config held until commit
    do_start();
    send_stream(mk_stream(vec_b), 2, 0, 0);
    check("reload_hold_regs", regs_config_in, 8'hA5);
    check("reload_cen", cen, 1);
    finish_load(1'b1, "reload");
    check("reload_regs", regs_config_in, 8'h00);

    // Reset after bit 70, then a full load
    do_start();
    send_stream(mk_stream(vec_a), 0, 70, 2);
    check("after_rst_cen", cen, 1);
    do_start();
    send_stream(mk_stream(vec_a), 2, 0, 0);
    finish_load(1'b1, "postrst");
    check("postrst_regs", regs_config_in, 8'hA5);

    // start pulsed at bit 40 is ignored
    vec_r = rand_vec();
    do_start();
    send_stream(mk_stream(vec_r), 0, 40, 1);
    finish_load(1'b1, "start40");
    check("start40_luts", luts_config_in, vec_r[NL-1:0]);

    // Random loads
    for (int n = 0; n < 6; n++) begin
      vec_r = rand_vec();
      do_start();
      send_stream(mk_stream(vec_r), 2, 0, 0);
      finish_load(1'b1, "rand");
      idle_noise();
    end

`ifdef CFG_PARITY_EN
    // Flipped parity bit: error, outputs kept, next start clears it
    vec_r = rand_vec();
    s = mk_stream(vec_r);
    s[NB] = ~s[NB];
    do_start();
    send_stream(s, 0, 0, 0);
    finish_load(1'b0, "parity_bad");
    check("parity_bad_regs", regs_config_in, m_cfg[NB-1:NL+3]);
    idle_noise();
    do_start();
    check("parity_err_clr", cfg_err, 0);
    send_stream(mk_stream(vec_a), 2, 0, 0);
    finish_load(1'b1, "parity_ok");
    check("parity_ok_regs", regs_config_in, 8'hA5);
`endif

    repeat (3) @(negedge cclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
